// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the data memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MAX_BURST  = 8;

  typedef enum logic {
    IDLE     = 1'b0,
    EXT_LOCK = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_burst_counter.sv
// Counts consecutive locked external grants; tc flags that the burst limit is reached.
import mem_arb_pkg::*;

module arb_burst_counter #(
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic incr,
  output logic tc
);

  localparam int CW = $clog2(MAX_BURST + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Load starts a new burst at one grant; increment tracks each further locked grant.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = CW'(1);
    end else if (incr) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register, cleared asynchronously so a reset aborts any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == CW'(MAX_BURST));

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter (processor and external loader/debug) in front of a single
// data memory with combinational read data; read data is returned one cycle later.
import mem_arb_pkg::*;

module data_mem_arbiter #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic                  ext_lock,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  arb_state_e state_q, state_d;
  owner_e     last_q, last_d;

  logic cnt_load;
  logic cnt_incr;
  logic cnt_tc;

  logic                  cpu_rvalid_q, cpu_rvalid_d;
  logic                  ext_rvalid_q, ext_rvalid_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] ext_rdata_q, ext_rdata_d;

  arb_burst_counter #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_counter (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .incr  (cnt_incr),
    .tc    (cnt_tc)
  );

  // Next-state and grant decode: a live locked burst keeps ext, otherwise round-robin in the same cycle.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cpu_gnt  = 1'b0;
    ext_gnt  = 1'b0;
    cnt_load = 1'b0;
    cnt_incr = 1'b0;
    if (state_q == EXT_LOCK && ext_req && ext_lock && !cnt_tc) begin
      ext_gnt  = 1'b1;
      cnt_incr = 1'b1;
    end else begin
      state_d = IDLE;
      if (cpu_req && (!ext_req || last_q == OWN_EXT)) begin
        cpu_gnt = 1'b1;
        last_d  = OWN_CPU;
      end else if (ext_req) begin
        ext_gnt = 1'b1;
        last_d  = OWN_EXT;
        if (ext_lock) begin
          state_d  = EXT_LOCK;
          cnt_load = 1'b1;
        end
      end
    end
    if (!reset) begin
      cpu_gnt  = 1'b0;
      ext_gnt  = 1'b0;
      cnt_load = 1'b0;
      cnt_incr = 1'b0;
      state_d  = IDLE;
      last_d   = OWN_EXT;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Steer the granted port onto the memory command bus; an idle bus is all zeros.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      mem_re    = ~cpu_we;
    end else if (ext_gnt) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_we    = ext_we;
      mem_re    = ~ext_we;
    end
  end

  // Capture read data for the granted reader; the data registers hold between reads.
  always_comb begin
    cpu_rvalid_d = cpu_gnt & ~cpu_we;
    ext_rvalid_d = ext_gnt & ~ext_we;
    cpu_rdata_d  = cpu_rdata_q;
    ext_rdata_d  = ext_rdata_q;
    if (cpu_rvalid_d) begin
      cpu_rdata_d = mem_rdata;
    end
    if (ext_rvalid_d) begin
      ext_rdata_d = mem_rdata;
    end
  end

  // State, last-winner pointer and read-return registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_q       <= OWN_EXT;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ext_rvalid_q <= ext_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign ext_rvalid = ext_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: expected read data is queued when a read
// grant is expected and popped when the corresponding rvalid cycle is sampled.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        ext_req, ext_we, ext_lock;
  logic [9:0]  ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] cpu_q[$];
  logic [31:0] ext_q[$];
  logic [31:0] last_cpu_rdata = '0;
  logic [31:0] last_ext_rdata = '0;

  // Memory model stores data XOR a per-address pattern so it starts out holding
  // init_val(addr) without any initialisation loop.
  bit   [31:0] mem_store [1024];
  logic [31:0] ref_mem   [1024];

  function automatic logic [31:0] init_val(input logic [9:0] a);
    return 32'hA500_0000 | {22'd0, a};
  endfunction

  always #5 clk = ~clk;

  assign mem_rdata = mem_store[mem_addr] ^ init_val(mem_addr);

  always @(posedge clk) begin
    if (mem_we) mem_store[mem_addr] <= mem_wdata ^ init_val(mem_addr);
  end

  data_mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_lock   (ext_lock),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reads granted last cycle must return now, in order; otherwise rdata must hold.
  task automatic checkReturns();
    logic [31:0] e;
    checkOutput("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, cpu_q.size() > 0});
    if (cpu_q.size() > 0) begin
      e = cpu_q.pop_front();
      checkOutput("cpu_rdata", cpu_rdata, e);
      last_cpu_rdata = e;
    end else begin
      checkOutput("cpu_rdata_hold", cpu_rdata, last_cpu_rdata);
    end
    checkOutput("ext_rvalid", {31'd0, ext_rvalid}, {31'd0, ext_q.size() > 0});
    if (ext_q.size() > 0) begin
      e = ext_q.pop_front();
      checkOutput("ext_rdata", ext_rdata, e);
      last_ext_rdata = e;
    end else begin
      checkOutput("ext_rdata_hold", ext_rdata, last_ext_rdata);
    end
  endtask

  task automatic applyStimulus(
    input logic c_req, input logic c_we, input logic [9:0] c_addr, input logic [31:0] c_wd,
    input logic e_req, input logic e_we, input logic e_lock, input logic [9:0] e_addr,
    input logic [31:0] e_wd, input logic exp_cg, input logic exp_eg);
    @(negedge clk);
    checkReturns();
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    ext_req = e_req; ext_we = e_we; ext_lock = e_lock; ext_addr = e_addr; ext_wdata = e_wd;
    #1;
    checkOutput("cpu_gnt", {31'd0, cpu_gnt}, {31'd0, exp_cg});
    checkOutput("ext_gnt", {31'd0, ext_gnt}, {31'd0, exp_eg});
    checkOutput("cpu_stall", {31'd0, cpu_stall}, {31'd0, c_req & ~exp_cg});
    if (exp_cg) begin
      checkOutput("mem_addr", {22'd0, mem_addr}, {22'd0, c_addr});
      checkOutput("mem_we", {31'd0, mem_we}, {31'd0, c_we});
      checkOutput("mem_re", {31'd0, mem_re}, {31'd0, ~c_we});
      checkOutput("mem_wdata", mem_wdata, c_wd);
      if (c_we) ref_mem[c_addr] = c_wd;
      else cpu_q.push_back(ref_mem[c_addr]);
    end else if (exp_eg) begin
      checkOutput("mem_addr", {22'd0, mem_addr}, {22'd0, e_addr});
      checkOutput("mem_we", {31'd0, mem_we}, {31'd0, e_we});
      checkOutput("mem_re", {31'd0, mem_re}, {31'd0, ~e_we});
      checkOutput("mem_wdata", mem_wdata, e_wd);
      if (e_we) ref_mem[e_addr] = e_wd;
      else ext_q.push_back(ref_mem[e_addr]);
    end else begin
      checkOutput("mem_addr_idle", {22'd0, mem_addr}, 32'd0);
      checkOutput("mem_we_idle", {31'd0, mem_we}, 32'd0);
      checkOutput("mem_re_idle", {31'd0, mem_re}, 32'd0);
      checkOutput("mem_wdata_idle", mem_wdata, 32'd0);
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Assert reset mid-cycle with the given ext locked write still presented,
  // then verify that nothing issues and all read state clears.
  task automatic resetCycle(input logic [9:0] e_addr, input logic [31:0] e_wd);
    @(negedge clk);
    checkReturns();
    ext_req = 1'b1; ext_we = 1'b1; ext_lock = 1'b1; ext_addr = e_addr; ext_wdata = e_wd;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = e_addr; cpu_wdata = e_wd;
    reset = 1'b0;
    #1;
    checkOutput("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    checkOutput("rst_ext_gnt", {31'd0, ext_gnt}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_mem_re", {31'd0, mem_re}, 32'd0);
    checkOutput("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    checkOutput("rst_ext_rvalid", {31'd0, ext_rvalid}, 32'd0);
    checkOutput("rst_cpu_rdata", cpu_rdata, 32'd0);
    checkOutput("rst_ext_rdata", ext_rdata, 32'd0);
    @(negedge clk);
    checkOutput("rst_hold_mem_we", {31'd0, mem_we}, 32'd0);
    cpu_q.delete();
    ext_q.delete();
    last_cpu_rdata = '0;
    last_ext_rdata = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; ext_req = 1'b0; ext_we = 1'b0; ext_lock = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) ref_mem[a] = init_val(10'(a));
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd1; cpu_wdata = 32'h1111_1111;
    ext_req = 1'b1; ext_we = 1'b1; ext_lock = 1'b1; ext_addr = 10'd2; ext_wdata = 32'h2222_2222;

    // Power-on reset with both ports requesting: nothing may be granted or written.
    resetCycle(10'd2, 32'h2222_2222);

    // Reset-release tie: cpu wins first, then ports alternate on back-to-back reads.
    applyStimulus(1'b1, 1'b0, 10'd5, 32'd0, 1'b1, 1'b0, 1'b0, 10'd9, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 10'd6, 32'd0, 1'b1, 1'b0, 1'b0, 10'd9, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 10'd7, 32'd0, 1'b1, 1'b0, 1'b0, 10'd11, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 10'd12, 32'd0, 1'b0, 1'b1);
    idleCycle();

    // CPU store then load of the same word.
    applyStimulus(1'b1, 1'b1, 10'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 10'd3, 32'd0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0);
    idleCycle();
    idleCycle();

    // Locked ext write burst against a waiting cpu: 8 ext grants, then cpu.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i <= 8, 1'b0, 10'd20, 32'd0,
                    1'b1, 1'b1, 1'b1, 10'(100 + i), 32'h5000_0000 + 32'(i),
                    i == 8, i != 8);
    end
    idleCycle();
    applyStimulus(1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 10'd104, 32'd0, 1'b0, 1'b1);

    // Lock dropped after 3 ext grants: the waiting cpu wins in the drop cycle.
    applyStimulus(1'b0, 1'b0, 10'd30, 32'd0, 1'b1, 1'b0, 1'b1, 10'd50, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 10'd30, 32'd0, 1'b1, 1'b0, 1'b1, 10'd51, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 10'd30, 32'd0, 1'b1, 1'b0, 1'b1, 10'd52, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 10'd30, 32'd0, 1'b1, 1'b0, 1'b0, 10'd53, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 10'd53, 32'd0, 1'b0, 1'b1);
    idleCycle();

    // Reset during the 4th locked write aborts the burst; cpu wins the next tie.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 10'd0, 32'd0,
                    1'b1, 1'b1, 1'b1, 10'(200 + i), 32'h7000_0000 + 32'(i), 1'b0, 1'b1);
    end
    resetCycle(10'd203, 32'h7000_0003);
    applyStimulus(1'b1, 1'b0, 10'd201, 32'd0, 1'b1, 1'b0, 1'b0, 10'd203, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 10'd203, 32'd0, 1'b0, 1'b1);

    // Quiet bus for five cycles.
    for (int i = 0; i < 5; i++) idleCycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, gives the word-address width (1024-word data memory).
REQ-002 Parameter DATA_WIDTH, default 32, gives the data word width.
REQ-003 Parameter MAX_BURST, default 8, gives the maximum number of consecutive locked external grants.
REQ-004 The block SHALL use one clock, clk; reset is asynchronous and active-low, named reset.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 cpu_req  input  1  processor load/store request (MemRead|MemWrite).
REQ-008 cpu_we  input  1  processor write (1) / read (0).
REQ-009 cpu_addr  input  ADDR_WIDTH  processor word address.
REQ-010 cpu_wdata  input  DATA_WIDTH  processor store data.
REQ-011 cpu_gnt  output  1  processor access accepted this cycle.
REQ-012 cpu_stall  output  1  equals cpu_req & ~cpu_gnt; holds the processor PC.
REQ-013 cpu_rvalid  output  1  processor read data valid.
REQ-014 cpu_rdata  output  DATA_WIDTH  processor read data.
REQ-015 ext_req, ext_we, ext_lock  input  1 each  external (loader/debug) request, write, burst lock.
REQ-016 ext_addr  input  ADDR_WIDTH and ext_wdata  input  DATA_WIDTH  external address and data.
REQ-017 ext_gnt, ext_rvalid  output  1 each and ext_rdata  output  DATA_WIDTH  external grant and read return.
REQ-018 mem_addr  output  ADDR_WIDTH, mem_wdata  output  DATA_WIDTH, mem_we and mem_re  output  1 each  memory command.
REQ-019 mem_rdata  input  DATA_WIDTH  combinational memory read data.

Function
REQ-020 Grants SHALL be combinational in the request cycle; at most one of cpu_gnt and ext_gnt SHALL be 1.
REQ-021 FSM states SHALL be IDLE, EXT_LOCK; a last-winner pointer (CPU/EXT) SHALL record the most recent grantee.
REQ-022 In IDLE, a single requester SHALL be granted; if both request, the port that is not the last winner SHALL be granted.
REQ-023 A grant to ext with ext_lock=1 in IDLE SHALL move to EXT_LOCK and set the burst count to 1.
REQ-024 In EXT_LOCK, while ext_req=1, ext_lock=1 and count<MAX_BURST, ext SHALL be granted exclusively and the count SHALL increment.
REQ-025 In EXT_LOCK, when ext_req=0 or ext_lock=0, the FSM SHALL return to IDLE and IDLE arbitration SHALL apply in that same cycle.
REQ-026 In EXT_LOCK, when count=MAX_BURST, the FSM SHALL return to IDLE with pointer=EXT, so a waiting cpu_req wins that cycle.
REQ-027 The granted port's addr/wdata SHALL drive mem_addr/mem_wdata, with mem_we=we and mem_re=~we; without a grant, all mem_* outputs SHALL be 0.
REQ-028 A granted read SHALL return mem_rdata, registered, on <port>_rdata with <port>_rvalid=1 for exactly the next cycle (latency 1).
REQ-029 A granted write SHALL produce no rvalid; rdata SHALL hold its last value when rvalid=0.
REQ-030 Back-to-back reads from alternating ports SHALL each return in order, with no lost rvalid.

Reset
REQ-031 While reset=0, all grants and mem_we/mem_re SHALL be forced 0, the state SHALL be IDLE, pointer=EXT, count=0, both rvalid=0 and both rdata=0.
REQ-032 Reset asserted mid-burst SHALL abort the burst immediately; no write SHALL issue in any reset cycle.

Structure
REQ-033 Package mem_arb_pkg SHALL hold the FSM state enum, the owner encoding (OWN_CPU, OWN_EXT) and default parameter constants.
REQ-034 The burst counter SHALL be one sub-module, arb_burst_counter (load, increment, terminal-count output).

Verification
REQ-035 Reset release, cpu_req=1 and ext_req=1 with reads of addresses 5 and 9 -> cpu granted first; cpu_rdata=mem[5] next cycle, then ext granted.
REQ-036 ext_lock=1 with ext writes held for 10 cycles and cpu_req=1 -> ext granted for 8 cycles and cpu_stall=1 throughout; cpu granted on the 9th cycle.
REQ-037 ext_lock dropped after 3 grants with cpu waiting -> cpu granted in the drop cycle.
REQ-038 cpu write of 0xDEADBEEF to addr 3, then cpu read of addr 3 -> mem_we=1 for one cycle, no rvalid on the write, cpu_rvalid=1 with 0xDEADBEEF.
REQ-039 reset=0 during the 4th locked write -> no mem_we in the reset cycle; after release, state=IDLE and cpu wins a tie.
REQ-040 No requests for 5 cycles -> all mem_* outputs, grants and rvalids stay 0.
